// File: rtl/shift_pkg.sv
//------------------------------------------------------------------------------
// Module   : shift_pkg
// Purpose  : Shared constants, op encodings and FSM state type for the serial
//            shift sequencer and its single-step shifter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package shift_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  localparam logic [1:0] OP_ROL = 2'd0;
  localparam logic [1:0] OP_SLL = 2'd1;
  localparam logic [1:0] OP_ROR = 2'd2;
  localparam logic [1:0] OP_ASR = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : shift_pkg

`default_nettype wire

// File: rtl/shift1.sv
//------------------------------------------------------------------------------
// Module   : shift1
// Purpose  : Single-step 16-bit shift/rotate stage (ROL, SLL, ROR, ASR by 1).
//            Purely combinational.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift1
  import shift_pkg::*;
(
  input  logic [15:0] din,
  input  logic [1:0]  op,
  output logic [15:0] dout
);

  // One-bit move of the operand according to the op encoding
  always_comb begin
    dout = din;
    case (op)
      OP_ROL:  dout = {din[14:0], din[15]};
      OP_SLL:  dout = {din[14:0], 1'b0};
      OP_ROR:  dout = {din[0], din[15:1]};
      OP_ASR:  dout = {din[15], din[15:1]};
      default: dout = din;
    endcase
  end

endmodule : shift1

`default_nettype wire

// File: rtl/serial_shift_ctrl.sv
//------------------------------------------------------------------------------
// Module   : serial_shift_ctrl
// Purpose  : Multi-cycle shift/rotate sequencer. Accepts an operand, op and
//            count over a valid/ready handshake, applies the shared 1-bit
//            shift stage once per clock until the count is exhausted, then
//            presents the result over a second valid/ready handshake.
// Config   : define SHIFT_STRIDE4_EN to add a 4-step datapath that consumes
//            four counts per cycle whenever at least four remain.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_shift_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH_P = shift_pkg::WIDTH,
  parameter int CNT_W_P = shift_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_P-1:0] in_data,
  input  logic [1:0]         in_op,
  input  logic [CNT_W_P-1:0] in_cnt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_P-1:0] out_data,
  output logic               busy
);

  state_t               r_state;
  logic [WIDTH_P-1:0]   r_data;
  logic [1:0]           r_op;
  logic [CNT_W_P-1:0]   r_cnt;

  logic [WIDTH_P-1:0]   w_step1;
  logic [WIDTH_P-1:0]   w_next_data;
  logic [CNT_W_P-1:0]   w_next_cnt;

  // Single-step datapath, always present
  shift1 u_step1 (
    .din  (r_data),
    .op   (r_op),
    .dout (w_step1)
  );

`ifdef SHIFT_STRIDE4_EN
  logic [WIDTH_P-1:0] w_chain [0:4];

  assign w_chain[0] = r_data;

  // Four chained stages give the 4-step result in one cycle
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_stride4
      shift1 u_step (
        .din  (w_chain[gi]),
        .op   (r_op),
        .dout (w_chain[gi+1])
      );
    end
  endgenerate

  // Take a 4-step stride while at least four counts remain
  always_comb begin
    if (r_cnt >= CNT_W_P'(4)) begin
      w_next_data = w_chain[4];
      w_next_cnt  = r_cnt - CNT_W_P'(4);
    end else begin
      w_next_data = w_step1;
      w_next_cnt  = r_cnt - CNT_W_P'(1);
    end
  end
`else
  // One step per cycle
  always_comb begin
    w_next_data = w_step1;
    w_next_cnt  = r_cnt - CNT_W_P'(1);
  end
`endif

  // Sequencer FSM, counter and data register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data  <= in_data;
            r_op    <= in_op;
            r_cnt   <= in_cnt;
            r_state <= (in_cnt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          r_data <= w_next_data;
          r_cnt  <= w_next_cnt;
          if (w_next_cnt == '0) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs come straight from state and the data register
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == SHIFT) || (r_state == DONE);
  assign out_data  = r_data;

endmodule : serial_shift_ctrl

`default_nettype wire

// File: tb/tb_serial_shift_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_shift_ctrl
// Purpose  : Directed self-checking bench for serial_shift_ctrl.
// Config   : honours SHIFT_STRIDE4_EN for expected latencies.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_serial_shift_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_op;
  logic [3:0]  in_cnt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int tests_run;
  int tests_failed;

  localparam int MAX_WAIT = 40;

  serial_shift_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_cnt    (in_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected edges from acceptance to out_valid
  function automatic int exp_lat(input int n);
`ifdef SHIFT_STRIDE4_EN
    return n / 4 + n % 4;
`else
    return n;
`endif
  endfunction

  // Present one request at a negedge, then wait (bounded) for out_valid.
  // Returns the number of edges after acceptance; MAX_WAIT means timeout.
  task automatic send_req(input logic [15:0] d, input logic [1:0] op,
                          input logic [3:0] cnt, output int edges);
    in_data  = d;
    in_op    = op;
    in_cnt   = cnt;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < MAX_WAIT) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_flags: got rdy/vld/busy=%b expected 100", {in_ready, out_valid, busy});
    end
    tests_run++;
    if (out_data !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_data: got %h expected 0000", out_data);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_rotate();
    int e;
    out_ready = 1'b1;
    send_req(16'h8001, 2'd0, 4'd1, e);
    tests_run++;
    if (e !== exp_lat(1)) begin
      tests_failed++;
      $display("FAIL rol_latency: got %0d expected %0d", e, exp_lat(1));
    end
    tests_run++;
    if (out_data !== 16'h0003) begin
      tests_failed++;
      $display("FAIL rol_data: got %h expected 0003", out_data);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rol_return_idle: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_full_sll();
    int e;
    int bad;
    out_ready = 1'b1;
    in_data  = 16'h0001;
    in_op    = 2'd1;
    in_cnt   = 4'd15;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    // Scramble inputs while busy; they must be ignored
    in_data = 16'hFFFF;
    in_op   = 2'd3;
    in_cnt  = 4'd2;
    e = 0;
    bad = 0;
    while (!out_valid && e < MAX_WAIT) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
      in_data = in_data ^ 16'h5A5A;
      @(posedge clk);
      @(negedge clk);
      e++;
    end
    tests_run++;
    if (e !== exp_lat(15)) begin
      tests_failed++;
      $display("FAIL sll15_latency: got %0d expected %0d", e, exp_lat(15));
    end
    tests_run++;
    if (out_data !== 16'h8000) begin
      tests_failed++;
      $display("FAIL sll15_data: got %h expected 8000", out_data);
    end
    tests_run++;
    if (bad !== 0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL sll15_busy: got %0d bad cycles busy=%b rdy=%b expected 0 1 0", bad, busy, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int e;
    int bad;
    out_ready = 1'b0;
    send_req(16'h8000, 2'd3, 4'd4, e);
    tests_run++;
    if (e !== exp_lat(4)) begin
      tests_failed++;
      $display("FAIL asr_latency: got %0d expected %0d", e, exp_lat(4));
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_data !== 16'hF800 || in_ready !== 1'b0) bad++;
      @(posedge clk);
      @(negedge clk);
    end
    tests_run++;
    if (bad !== 0 || out_data !== 16'hF800 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL asr_hold: got %0d bad cycles data=%h vld=%b expected 0 F800 1", bad, out_data, out_valid);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL asr_release: got rdy=%b vld=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_zero_count();
    int e;
    out_ready = 1'b1;
    send_req(16'h1234, 2'd2, 4'd0, e);
    tests_run++;
    if (e !== 0) begin
      tests_failed++;
      $display("FAIL zero_latency: got %0d expected 0", e);
    end
    tests_run++;
    if (out_data !== 16'h1234) begin
      tests_failed++;
      $display("FAIL zero_data: got %h expected 1234", out_data);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready = 1'b1;
    in_data  = 16'h0001;
    in_op    = 2'd2;
    in_cnt   = 4'd10;
    in_valid = 1'b1;
    @(posedge clk);               // E0
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);    // E0+1, E0+2
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);               // E0+3
    @(negedge clk);
    tests_run++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 16'h0000) begin
      tests_failed++;
      $display("FAIL midreset_state: got rdy/vld/busy=%b data=%h expected 100 0000",
               {in_ready, out_valid, busy}, out_data);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL midreset_no_result: got %0d valid cycles expected 0", seen);
    end
  endtask

  task automatic test_ops();
    logic [15:0] vd [0:4];
    logic [1:0]  vo [0:4];
    logic [3:0]  vc [0:4];
    logic [15:0] vr [0:4];
    int e;
    vd[0] = 16'h0001; vo[0] = 2'd2; vc[0] = 4'd15; vr[0] = 16'h0002;
    vd[1] = 16'h7FFF; vo[1] = 2'd3; vc[1] = 4'd3;  vr[1] = 16'h0FFF;
    vd[2] = 16'hF000; vo[2] = 2'd0; vc[2] = 4'd3;  vr[2] = 16'h8007;
    vd[3] = 16'h0001; vo[3] = 2'd2; vc[3] = 4'd5;  vr[3] = 16'h0800;
    vd[4] = 16'h00F1; vo[4] = 2'd1; vc[4] = 4'd7;  vr[4] = 16'h7880;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_req(vd[i], vo[i], vc[i], e);
      tests_run++;
      if (e !== exp_lat(int'(vc[i]))) begin
        tests_failed++;
        $display("FAIL ops%0d_latency: got %0d expected %0d", i, e, exp_lat(int'(vc[i])));
      end
      tests_run++;
      if (out_data !== vr[i]) begin
        tests_failed++;
        $display("FAIL ops%0d_data: got %h expected %h", i, out_data, vr[i]);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int e;
    out_ready = 1'b1;
    // Hold in_valid high across two requests and time acceptances
    in_data  = 16'h0003;
    in_op    = 2'd1;
    in_cnt   = 4'd2;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_data = 16'hF000;
    in_op   = 2'd0;
    in_cnt  = 4'd3;
    cyc = 0;
    while (!out_valid && cyc < MAX_WAIT) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (out_data !== 16'h000C) begin
      tests_failed++;
      $display("FAIL b2b_first_data: got %h expected 000C", out_data);
    end
    // Handshake edge, then one IDLE cycle in which the next request is taken
    @(posedge clk);
    @(negedge clk);
    cyc++;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_bubble: got rdy=%b expected 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    in_valid = 1'b0;
    tests_run++;
    if (cyc !== exp_lat(2) + 2 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_throughput: got %0d cycles busy=%b expected %0d 1", cyc, busy, exp_lat(2) + 2);
    end
    e = (out_valid) ? 0 : 1;
    while (!out_valid && e < MAX_WAIT) begin
      @(posedge clk);
      @(negedge clk);
      e++;
    end
    tests_run++;
    if (out_data !== 16'h8007) begin
      tests_failed++;
      $display("FAIL b2b_second_data: got %h expected 8007", out_data);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_op     = '0;
    in_cnt    = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_rotate();
    test_full_sll();
    test_backpressure();
    test_zero_count();
    test_reset_mid();
    test_ops();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_serial_shift_ctrl

`default_nettype wire
